// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control block.
//   state_e      : control FSM states (run, drain, halted, single step)
//   FWD_*        : operand-select codes driven on fwda/fwdb
//   DRAIN_CYCLES : bubble cycles needed to retire EXE/MEM/WB before halting
// Helper functions decide whether a stage produces a source register and pick
// the highest-priority forwarding source.
package pipe_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2,
    StStep   = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int unsigned DRAIN_CYCLES = 3;

  // r0 is hardwired to zero, so nothing ever produces it.
  function automatic logic is_producer(input logic [4:0] dest, input logic wr,
                                       input logic [4:0] src);
    return wr && (dest == src) && (src != 5'd0);
  endfunction

  // Youngest producer wins: EXE over MEM over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] edest, input logic ewr,
                                         input logic [4:0] mdest, input logic mwr,
                                         input logic [4:0] wdest, input logic wwr);
    if (is_producer(edest, ewr, src)) return FWD_EXE;
    if (is_producer(mdest, mwr, src)) return FWD_MEM;
    if (is_producer(wdest, wwr, src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand-dependency unit.
// Build option: PIPE_CTRL_FWD_EN
//   defined   : forward from EXE/MEM/WB; only a load in EXE feeding ID stalls
//   undefined : no forwarding (selects stay FWD_RF); any pending producer stalls
// Ports:
//   drs_i, drt_i, duses_rt_i          ID-stage sources and rt-use flag
//   edest_i, ewreg_i, em2reg_i        EXE destination, write flag, load flag
//   mdest_i, mwreg_i                  MEM destination, write flag
//   wdest_i, wwreg_i                  WB destination, write flag
//   hazard_o                          ID instruction must wait this cycle
//   fwda_o, fwdb_o                    operand select for rs / rt
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] drs_i,
  input  logic [4:0] drt_i,
  input  logic       duses_rt_i,
  input  logic [4:0] edest_i,
  input  logic       ewreg_i,
  input  logic       em2reg_i,
  input  logic [4:0] mdest_i,
  input  logic       mwreg_i,
  input  logic [4:0] wdest_i,
  input  logic       wwreg_i,
  output logic       hazard_o,
  output logic [1:0] fwda_o,
  output logic [1:0] fwdb_o
);

  logic rs_exe, rt_exe;

  assign rs_exe = is_producer(edest_i, ewreg_i, drs_i);
  assign rt_exe = is_producer(edest_i, ewreg_i, drt_i) && duses_rt_i;

`ifdef PIPE_CTRL_FWD_EN
  // Loaded data is not available until MEM, so an EXE load cannot be forwarded.
  assign hazard_o = ewreg_i && em2reg_i && (rs_exe || rt_exe);
  assign fwda_o   = fwd_sel(drs_i, edest_i, ewreg_i, mdest_i, mwreg_i, wdest_i, wwreg_i);
  assign fwdb_o   = fwd_sel(drt_i, edest_i, ewreg_i, mdest_i, mwreg_i, wdest_i, wwreg_i);
`else
  logic rs_later, rt_later;

  assign rs_later = is_producer(mdest_i, mwreg_i, drs_i) || is_producer(wdest_i, wwreg_i, drs_i);
  assign rt_later = (is_producer(mdest_i, mwreg_i, drt_i) ||
                     is_producer(wdest_i, wwreg_i, drt_i)) && duses_rt_i;
  // The load-use term is a subset of the EXE match; kept so em2reg means the
  // same thing in both builds.
  assign hazard_o = (ewreg_i && em2reg_i && (rs_exe || rt_exe)) ||
                    rs_exe || rt_exe || rs_later || rt_later;
  assign fwda_o   = FWD_RF;
  assign fwdb_o   = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: hazard stalls, operand forwarding and debug halt/step.
// Build option: PIPE_CTRL_FWD_EN (see fwd_unit) selects forwarding vs. full
// interlock.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   drs, drt, duses_rt                ID-stage sources
//   edestReg, ewreg, em2reg           EXE stage producer info
//   mdestReg, mwreg                   MEM stage producer info
//   wdestReg, wwreg                   WB stage producer info
//   halt_req, step_req                debug halt level / single-step pulse
//   pc_en, ifid_en, bubble            front-end enables and ID/EXE bubble
//   fwda, fwdb                        operand selects (0 RF, 1 EXE, 2 MEM, 3 WB)
//   halted                            core is parked in the halted state
//   stall_cnt                         saturating count of hazard-stall cycles
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        duses_rt,
  input  logic [4:0]  edestReg,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  mdestReg,
  input  logic        mwreg,
  input  logic [4:0]  wdestReg,
  input  logic        wwreg,
  input  logic        halt_req,
  input  logic        step_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        bubble,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] DrainLast = 2'(DRAIN_CYCLES - 1);

  state_e      state_q;
  logic [1:0]  drain_q;
  logic        halted_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        hazard;
  logic        stall_cycle;
  logic        hold;

  fwd_unit u_fwd_unit (
    .drs_i      (drs),
    .drt_i      (drt),
    .duses_rt_i (duses_rt),
    .edest_i    (edestReg),
    .ewreg_i    (ewreg),
    .em2reg_i   (em2reg),
    .mdest_i    (mdestReg),
    .mwreg_i    (mwreg),
    .wdest_i    (wdestReg),
    .wwreg_i    (wwreg),
    .hazard_o   (hazard),
    .fwda_o     (fwda),
    .fwdb_o     (fwdb)
  );

  // Only instruction-issuing states can stall on a hazard; DRAIN/HALTED are
  // already frozen and do not count.
  assign stall_cycle = hazard && ((state_q == StRun) || (state_q == StStep));
  assign hold        = stall_cycle || (state_q == StDrain) || (state_q == StHalted);

  assign pc_en     = ~hold;
  assign ifid_en   = ~hold;
  assign bubble    = hold;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      drain_q  <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          // A pending stall finishes before the halt is honoured.
          if (!hazard && halt_req) begin
            state_q <= StDrain;
            drain_q <= 2'd0;
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            state_q  <= StHalted;
            drain_q  <= 2'd0;
            halted_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        StHalted: begin
          if (!halt_req) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end else if (step_req) begin
            state_q  <= StStep;
            halted_q <= 1'b0;
          end
        end
        StStep: begin
          // The stepped instruction must actually issue; wait out any hazard.
          if (!hazard) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StRun;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock (rising edge); rst in 1, synchronous active-high reset.
REQ-002 SHALL have ports: drs in 5 and drt in 5, ID-stage source registers; duses_rt in 1, ID instruction reads rt.
REQ-003 SHALL have ports: edestReg in 5, ewreg in 1, em2reg in 1 (EXE stage); mdestReg in 5, mwreg in 1 (MEM stage); wdestReg in 5, wwreg in 1 (WB stage).
REQ-004 SHALL have ports: halt_req in 1, level debug halt request; step_req in 1, single-cycle step pulse.
REQ-005 SHALL have ports: pc_en out 1, PC load enable; ifid_en out 1, IF/ID load enable; bubble out 1, zero control fields into ID/EXE.
REQ-006 SHALL have ports: fwda out 2 and fwdb out 2, operand select (0 regfile, 1 EXE r, 2 MEM mr/mdo, 3 WB wr/wdo); halted out 1; stall_cnt out 16.

Function
REQ-007 SHALL treat a stage as a producer for register x only when its write flag is 1, its destReg==x, and x!=0.
REQ-008 SHALL raise load-use hazard when ewreg&em2reg and edestReg matches drs, or matches drt with duses_rt=1.
REQ-009 SHALL, with forwarding, choose fwda/fwdb by priority EXE > MEM > WB, combinationally, same cycle.
REQ-010 SHALL, on a hazard in RUN, drive pc_en=0, ifid_en=0, bubble=1 that cycle; hazard clearing restores pc_en=ifid_en=1, bubble=0 next cycle.
REQ-011 SHALL implement FSM states RUN, DRAIN, HALTED, STEP.
REQ-012 RUN->DRAIN when halt_req=1 and no hazard this cycle; if a hazard exists, the stall completes first.
REQ-013 DRAIN: pc_en=0, ifid_en=0, bubble=1 for exactly 3 cycles (2-bit counter), then HALTED; retires EXE/MEM/WB.
REQ-014 HALTED: pc_en=0, ifid_en=0, bubble=1, halted=1; halt_req=0 -> RUN next cycle; step_req=1 (with halt_req=1) -> STEP.
REQ-015 STEP: one cycle pc_en=1, ifid_en=1, bubble=0, halted=0, then HALTED; if a hazard is present, STEP acts as a stall cycle and stays in STEP.
REQ-016 SHALL ignore step_req outside HALTED; halt_req and step_req both 1 in HALTED -> STEP.
REQ-017 stall_cnt SHALL increment by 1 on each hazard-stall cycle (not DRAIN/HALTED), saturating at 16'hFFFF.

Reset
REQ-018 On rst=1 at a clk edge: state=RUN, drain counter=0, stall_cnt=0, halted=0; rst overrides every transition, including mid-DRAIN.
REQ-019 During and after reset, pc_en=1, ifid_en=1, bubble=0, fwda=fwdb=0 unless REQ-009/010 drive otherwise.

Configuration
REQ-020 Macro PIPE_CTRL_FWD_EN defined: forwarding per REQ-009; only load-use hazards stall.
REQ-021 Macro PIPE_CTRL_FWD_EN undefined: fwda=fwdb=0 constant; any REQ-007 match in EXE, MEM or WB against a used source is a hazard and stalls until it clears.

Structure
REQ-022 Shared package pipe_pkg SHALL hold the FSM state enum, forwarding-select constants (FWD_RF, FWD_EXE, FWD_MEM, FWD_WB), and DRAIN_CYCLES=3.
REQ-023 Forwarding/hazard compare logic SHALL be one combinational sub-module, fwd_unit; pipe_ctrl holds the FSM, counters, and enables.

Verification
REQ-024 FWD_EN: edestReg=5, ewreg=1, em2reg=0, drs=5 -> fwda=1, pc_en=1, no stall.
REQ-025 FWD_EN: em2reg=1, edestReg=7, drt=7, duses_rt=1 -> one cycle pc_en=0, bubble=1, stall_cnt 0->1; next cycle with mdestReg=7 -> fwdb=2.
REQ-026 Destination 0 with all write flags set and drs=drt=0 -> fwda=fwdb=0, no stall.
REQ-027 halt_req=1 in RUN -> 3 DRAIN cycles with bubble=1, then halted=1; step_req pulse -> exactly one cycle pc_en=1, then halted=1 again; halt_req=0 -> RUN.
REQ-028 rst=1 during the 2nd DRAIN cycle -> next cycle state RUN, halted=0, stall_cnt=0.
REQ-029 FWD_EN undefined: mdestReg=3, mwreg=1, drs=3 -> stall until that producer leaves WB, fwda stays 0.
